count_sequencer: RTL and testbench
==================================

# count_sequencer

Run-control sequencer for the signed 8-bit hex counter datapath. It owns the tick prescaler and the count register. It turns two pushbuttons and three switch fields into run, pause, clear, direction, rate and limit behaviour. Its `value`, `mag` and `neg` outputs feed the existing hex7seg and Negative display instances directly.

## Interface
- `TICK_DIV`, default 10000000: CLOCK_50 cycles per count step at rate 0. Must be ≥ 8 and a multiple of 8.
- `CLOCK_50`  in  1  system clock; the only clock in the block.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `key_run_n`  in  1  raw run/pause pushbuttons, active-low, asynchronous to the clock.
- `key_clear_n`  in  1  raw clear pushbutton, active-low, asynchronous to the clock.
- `sw_dir`  in  1  count direction: 0 = up, 1 = down.
- `sw_rate`  in  2  step period select: `TICK_DIV >> sw_rate`.
- `sw_wrap`  in  1  limit behaviour: 1 = wrap, 0 = saturate and stop.
- `value`  out  8  count, two's complement.
- `mag`  out  8  unsigned magnitude of `value` (0..128).
- `neg`  out  1  equals `value[7]`.
- `running`  out  1  high while in state RUN.
- `step`  out  1  one-cycle pulse on the same edge at which `value` changes.
- `done`  out  1  high while in state LIMIT.

## Operation
- **Key inputs**
  - Each key passes through a 2-FF synchronizer and then an edge register.
  - An action fires on a synchronized falling edge only. Holding a key produces one action.
  - Synchronizer and edge registers reset to 1, so releasing reset never produces a false edge.
- **Prescaler**
  - `presc` counts only in RUN.
  - When `presc >= (TICK_DIV >> sw_rate) - 1`: `presc` returns to 0 and a step occurs.
  - The `>=` comparison means lowering the period mid-count steps on the next cycle; it never runs long.
- **Step**
  - `value` becomes `value + 1` (`sw_dir`=0) or `value - 1` (`sw_dir`=1).
  - `sw_dir` and `sw_wrap` are sampled at the step edge.
- **Limits**
  - With `sw_wrap`=1: +127 up goes to -128; -128 down goes to +127.
  - With `sw_wrap`=0: a step that would cross a limit leaves `value` unchanged, does not pulse `step`, and moves the FSM to LIMIT.
- **FSM states:** IDLE, RUN, PAUSE, LIMIT.
  - IDLE: run edge → RUN.
  - RUN: run edge → PAUSE; `presc` is held, not cleared.
  - PAUSE: run edge → RUN; the prescaler resumes from its held count.
  - LIMIT: run edge → RUN only if `sw_dir` points away from the current limit (down at +127, up at -128); otherwise stay in LIMIT.
  - Any state: clear edge → IDLE with `value`=0 and `presc`=0.
- **Simultaneous events**
  - A clear edge wins over a run edge.
  - A clear edge wins over a step in the same cycle: `value` goes to 0 and `step` stays 0.
  - A run edge coinciding with a step in RUN: the step is applied, then the FSM goes to PAUSE.
- **Output decode**
  - `mag` is combinational: `neg ? -value : value`, 8-bit unsigned, so -128 gives 128.
  - `neg` is combinational from `value`.

## Timing
- **Reset values:** state IDLE, `value`=0, `mag`=0, `neg`=0, `running`=0, `step`=0, `done`=0, `presc`=0.
- **Reset mid-operation:** asserting reset in any state returns everything to the reset values immediately; reset is asynchronous.
- **Key latency:** a key that goes low before rising edge k takes effect on edge k+2.
  - At edge k the first synchronizer flop captures it.
  - At edge k+1 the second flop holds it and the edge register still holds 1.
  - At edge k+2 the FSM state changes.
- **Step timing:**
  - The first step after entering RUN from IDLE occurs exactly `TICK_DIV >> sw_rate` cycles after the transition edge.
  - Steps then repeat every `TICK_DIV >> sw_rate` cycles.
- **Registered outputs:** `value`, `step`, `running` and `done` are registered and update on the same edge.
- **Combinational outputs:** `mag` and `neg` follow `value` in the same cycle.
- **Step pulse:** `step` is high for exactly one cycle per value change. It is never high in IDLE, PAUSE or LIMIT.

## Test plan
All scenarios use `TICK_DIV`=8.
1. **Reset and rate 0 stepping.** Reset, then a run press with `sw_rate`=0, `sw_dir`=0.
   - `running`=1 two edges after the press.
   - `value` = 1, 2, 3 at 8-cycle spacing, with `step` pulses aligned to each change.
   - `mag` equals `value` and `neg`=0 throughout.
2. **Down count across zero.** `sw_dir`=1, `sw_rate`=3, run from 0.
   - `value` = -1 (0xFF), then -2, one step per cycle.
   - `neg`=1 and `mag`=1, 2.
3. **Wrap and saturate.**
   - Preload to +127 by counting up with `sw_rate`=3, `sw_wrap`=1: the next step gives `value`=-128, `mag`=128, `neg`=1.
   - Repeat with `sw_wrap`=0: `value` holds at 127, `done`=1, `running`=0, no `step` pulse.
   - A run press with `sw_dir`=0 keeps `done`=1.
   - Set `sw_dir`=1 and press run: RUN resumes and the next step gives 126.
4. **Pause and resume.** Press run at `presc`=5, `sw_rate`=0, wait 100 cycles, press run again.
   - No step occurs during the pause.
   - The first step after resuming lands 3 cycles after the resume transition.
5. **Clear priority.** Hold both keys so their falling edges land in the same cycle while in RUN with `value`=10.
   - State goes to IDLE, `value`=0, `step`=0.
   - Holding the keys low for 50 more cycles produces no further action.
6. **Async reset mid-run.** Pulse `reset_n` low mid-cycle in RUN with `value`=-5.
   - All outputs reach their reset values before the next clock edge.
   - No spurious run action occurs after release.

Source files
------------

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// count_sequencer : run/pause/clear/limit sequencer for a signed 8-bit counter
// Revision 1.0
// ============================================================================
module count_sequencer #(
  parameter int TICK_DIV = 10000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_run_n,
  input  logic       key_clear_n,
  input  logic       sw_dir,
  input  logic [1:0] sw_rate,
  input  logic       sw_wrap,
  output logic [7:0] value,
  output logic [7:0] mag,
  output logic       neg,
  output logic       running,
  output logic       step,
  output logic       done
);

  localparam int              PW    = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0]   c_div = PW'(TICK_DIV);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_pause = 2'd2;
  localparam logic [1:0] c_limit = 2'd3;

  logic          r_run_s1, r_run_s2, r_run_d;
  logic          r_clr_s1, r_clr_s2, r_clr_d;
  logic [1:0]    r_state, w_state_nxt;
  logic [7:0]    r_value, w_value_nxt, w_stepped;
  logic [PW-1:0] r_presc, w_presc_nxt, w_period;
  logic          r_step, w_step_nxt, r_running, r_done;
  logic          w_run_edge, w_clr_edge, w_hit;
  logic          w_at_max, w_at_min, w_blocked;

  // Synchronizer and edge flops idle high so reset release never looks like a press
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      {r_run_s1, r_run_s2, r_run_d} <= 3'b111;
      {r_clr_s1, r_clr_s2, r_clr_d} <= 3'b111;
    end else begin
      r_run_s1 <= key_run_n;
      r_run_s2 <= r_run_s1;
      r_run_d  <= r_run_s2;
      r_clr_s1 <= key_clear_n;
      r_clr_s2 <= r_clr_s1;
      r_clr_d  <= r_clr_s2;
    end
  end

  assign w_run_edge = r_run_d & ~r_run_s2;
  assign w_clr_edge = r_clr_d & ~r_clr_s2;

  // >= rather than == so shortening the period mid-count steps at once
  assign w_period  = c_div >> sw_rate;
  assign w_hit     = (r_presc >= (w_period - 1'b1));

  assign w_at_max  = (r_value == 8'h7F);
  assign w_at_min  = (r_value == 8'h80);
  assign w_blocked = ~sw_wrap & (sw_dir ? w_at_min : w_at_max);
  assign w_stepped = sw_dir ? (r_value - 8'd1) : (r_value + 8'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_presc_nxt = r_presc;
    w_step_nxt  = 1'b0;
    if (w_clr_edge) begin
      w_state_nxt = c_idle;
      w_value_nxt = 8'd0;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_run_edge) begin
            w_state_nxt = c_run;
            w_presc_nxt = '0;
          end
        end
        c_run: begin
          if (w_hit) begin
            w_presc_nxt = '0;
            if (w_blocked) begin
              w_state_nxt = c_limit;
            end else begin
              w_value_nxt = w_stepped;
              w_step_nxt  = 1'b1;
              if (w_run_edge) w_state_nxt = c_pause;
            end
          end else if (w_run_edge) begin
            w_state_nxt = c_pause;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        c_pause: begin
          if (w_run_edge) w_state_nxt = c_run;
        end
        default: begin
          // Leave the limit only when the direction points back into range
          if (w_run_edge && (w_at_max ? sw_dir : ~sw_dir)) w_state_nxt = c_run;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_idle;
      r_value   <= 8'd0;
      r_presc   <= '0;
      r_step    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_value   <= w_value_nxt;
      r_presc   <= w_presc_nxt;
      r_step    <= w_step_nxt;
      r_running <= (w_state_nxt == c_run);
      r_done    <= (w_state_nxt == c_limit);
    end
  end

  assign value   = r_value;
  assign neg     = r_value[7];
  assign mag     = r_value[7] ? (8'd0 - r_value) : r_value;
  assign running = r_running;
  assign step    = r_step;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// tb_count_sequencer : directed vector bench for count_sequencer (TICK_DIV=8)
// Revision 1.0
// ============================================================================
module tb_count_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       key_run_n, key_clear_n, sw_dir, sw_wrap;
  logic [1:0] sw_rate;
  logic [7:0] value, mag;
  logic       neg, running, step, done;

  int checks   = 0;
  int failures = 0;

  count_sequencer #(.TICK_DIV(8)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .key_run_n   (key_run_n),
    .key_clear_n (key_clear_n),
    .sw_dir      (sw_dir),
    .sw_rate     (sw_rate),
    .sw_wrap     (sw_wrap),
    .value       (value),
    .mag         (mag),
    .neg         (neg),
    .running     (running),
    .step        (step),
    .done        (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       run_n;
    logic       clr_n;
    logic       dir;
    logic [1:0] rate;
    logic       wrap;
    logic [7:0] cycles;
    logic [7:0] exp_value;
    logic [7:0] exp_mag;
    logic       exp_neg;
    logic       exp_running;
    logic       exp_step;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mag_model(input logic [7:0] v);
    logic [8:0] t;
    t = v[7] ? (9'd256 - {1'b0, v}) : {1'b0, v};
    return t[7:0];
  endfunction

  task automatic check_out(input string name, input logic [7:0] v, input logic r,
                           input logic s, input logic d);
    chk({name, ".value"},   value,   v);
    chk({name, ".mag"},     mag,     mag_model(v));
    chk({name, ".neg"},     neg,     v[7]);
    chk({name, ".running"}, running, r);
    chk({name, ".step"},    step,    s);
    chk({name, ".done"},    done,    d);
  endtask

  task automatic press_run();
    key_run_n = 1'b0;
    tick();
    tick();
    key_run_n = 1'b1;
    tick();
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    tick();
    tick();
    key_clear_n = 1'b1;
    tick();
  endtask

  task automatic wait_value(input string name, input logic [7:0] v, input int bound);
    int n;
    n = 0;
    while (value !== v && n < bound) begin
      tick();
      n++;
    end
    chk({name, ".reached"}, value, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    reset_n     = 1'b0;
    key_run_n   = 1'b1;
    key_clear_n = 1'b1;
    sw_dir      = 1'b0;
    sw_rate     = 2'd0;
    sw_wrap     = 1'b1;

    // run_n clr_n dir rate wrap cycles | value mag neg running step done
    vecs.push_back('{1'b0,1'b1,1'b0,2'd0,1'b1,8'd2, 8'h00,8'h00,1'b0,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd1, 8'h00,8'h00,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd7, 8'h00,8'h00,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd1, 8'h01,8'h01,1'b0,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd7, 8'h01,8'h01,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd1, 8'h02,8'h02,1'b0,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd7, 8'h02,8'h02,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd1, 8'h03,8'h03,1'b0,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b0,2'd0,1'b1,8'd2, 8'h03,8'h03,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,2'd0,1'b1,8'd1, 8'h00,8'h00,1'b0,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'd3,1'b1,8'd2, 8'h00,8'h00,1'b0,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd1, 8'h00,8'h00,1'b0,1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFF,8'h01,1'b1,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFE,8'h02,1'b1,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFD,8'h03,1'b1,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFC,8'h04,1'b1,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFB,8'h05,1'b1,1'b1,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd1, 8'hFA,8'h06,1'b1,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'd3,1'b1,8'd3, 8'hFA,8'h06,1'b1,1'b0,1'b0,1'b0});

    // Reset held across a clock edge, then released between edges
    #12;
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      key_run_n   = vecs[i].run_n;
      key_clear_n = vecs[i].clr_n;
      sw_dir      = vecs[i].dir;
      sw_rate     = vecs[i].rate;
      sw_wrap     = vecs[i].wrap;
      for (int c = 0; c < int'(vecs[i].cycles); c++) begin
        tick();
        chk($sformatf("vec%0d.value", i),   value,   vecs[i].exp_value);
        chk($sformatf("vec%0d.mag", i),     mag,     vecs[i].exp_mag);
        chk($sformatf("vec%0d.neg", i),     neg,     vecs[i].exp_neg);
        chk($sformatf("vec%0d.running", i), running, vecs[i].exp_running);
        chk($sformatf("vec%0d.step", i),    step,    vecs[i].exp_step);
        chk($sformatf("vec%0d.done", i),    done,    vecs[i].exp_done);
      end
    end

    // Wrap at +127, then saturate at +127
    press_clear();
    check_out("clear_from_pause", 8'h00, 1'b0, 1'b0, 1'b0);
    sw_dir = 1'b0; sw_rate = 2'd3; sw_wrap = 1'b1;
    press_run();
    wait_value("to_127_wrap", 8'h7F, 200);
    tick();
    check_out("wrap_up", 8'h80, 1'b1, 1'b1, 1'b0);
    sw_wrap = 1'b0;
    wait_value("to_127_sat", 8'h7F, 400);
    tick();
    check_out("sat_up", 8'h7F, 1'b0, 1'b0, 1'b1);
    repeat (4) begin
      tick();
      check_out("sat_hold", 8'h7F, 1'b0, 1'b0, 1'b1);
    end
    press_run();
    check_out("limit_wrong_dir", 8'h7F, 1'b0, 1'b0, 1'b1);
    sw_dir = 1'b1;
    press_run();
    check_out("limit_resume", 8'h7F, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("limit_step_down", 8'h7E, 1'b1, 1'b1, 1'b0);

    // Pause with the prescaler at 5, resume 3 cycles from the next step
    press_clear();
    check_out("clear_from_run", 8'h00, 1'b0, 1'b0, 1'b0);
    sw_dir = 1'b0; sw_rate = 2'd0; sw_wrap = 1'b1;
    press_run();
    check_out("run_again", 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    press_run();
    check_out("paused", 8'h00, 1'b0, 1'b0, 1'b0);
    bad = 0;
    repeat (100) begin
      tick();
      if (step !== 1'b0 || value !== 8'h00 || running !== 1'b0) bad++;
    end
    chk("pause_quiet", bad, 0);
    press_run();
    check_out("resumed", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("resume_r1.step", step, 1'b0);
    tick();
    chk("resume_r2.step", step, 1'b0);
    tick();
    check_out("resume_r3", 8'h01, 1'b1, 1'b1, 1'b0);

    // Clear and run edges together, landing on a step edge
    sw_rate = 2'd3;
    wait_value("to_10", 8'h0A, 50);
    sw_rate = 2'd0;
    repeat (5) tick();
    check_out("hold_10", 8'h0A, 1'b1, 1'b0, 1'b0);
    key_run_n = 1'b0; key_clear_n = 1'b0;
    repeat (3) tick();
    check_out("clear_wins", 8'h00, 1'b0, 1'b0, 1'b0);
    bad = 0;
    repeat (50) begin
      tick();
      if (running !== 1'b0 || value !== 8'h00 || step !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("keys_held_quiet", bad, 0);
    key_run_n = 1'b1; key_clear_n = 1'b1;
    repeat (3) tick();
    check_out("keys_released", 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a clock cycle
    sw_dir = 1'b1; sw_rate = 2'd3;
    press_run();
    repeat (5) tick();
    check_out("pre_reset", 8'hFB, 1'b1, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1 check_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (running !== 1'b0 || value !== 8'h00 || step !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
